// File: rtl/periph_pkg.sv
// periph_pkg: register offsets, FSM state encodings and CTRL bit positions for periph_responder
package periph_pkg;
  localparam logic [2:0] OFS_STATUS   = 3'd0;
  localparam logic [2:0] OFS_CTRL     = 3'd1;
  localparam logic [2:0] OFS_TIMER    = 3'd2;
  localparam logic [2:0] OFS_CMP      = 3'd3;
  localparam logic [2:0] OFS_GPIO_OUT = 3'd4;
  localparam logic [2:0] OFS_GPIO_IN  = 3'd5;
  localparam logic [2:0] OFS_SCRATCH  = 3'd6;
  localparam int CTRL_TEN = 0;
  localparam int CTRL_IEN = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/periph_timer.sv
// periph_timer: 16-bit free-running timer with load, compare and sticky match flag cleared by w1c
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic [15:0] cmp,
  input  logic        w1c,
  output logic [15:0] count,
  output logic        flag
);
  // load beats increment; a match on the pre-increment value beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count <= '0;
      flag  <= 1'b0;
    end else begin
      count <= load ? load_val : en ? count + 16'd1 : count;
      flag  <= (en && count == cmp) ? 1'b1 : w1c ? 1'b0 : flag;
    end
endmodule

// File: rtl/periph_responder.sv
// periph_responder: peripheral-space bus responder with timer, GPIO and scratch; PERIPH_WAIT_EN adds wait states
module periph_responder
  import periph_pkg::*;
#(
  parameter int GPIO_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  output logic              ack,
  output logic [15:0]       rdata,
  output logic              err,
  output logic              irq,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in
);
  state_t state, state_nx;
  logic start, fire, we, miss, wr, flag;
  logic [14:0] addr;
  logic [15:0] wdata, rd_val, count, cmp, scratch;
  logic [2:0] ofs;
  logic [1:0] ctrl;
  logic [GPIO_W-1:0] gpio_meta, gpio_sync;

  assign start = state == ST_IDLE && req && req_addr[15];

`ifdef PERIPH_WAIT_EN
  logic [3:0] cnt;
  logic lat_we;
  logic [14:0] lat_addr;
  logic [15:0] lat_wdata;
  assign we    = state == ST_IDLE ? req_we : lat_we;
  assign addr  = state == ST_IDLE ? req_addr[14:0] : lat_addr;
  assign wdata = state == ST_IDLE ? req_wdata : lat_wdata;
  assign fire  = (start && WAIT_CYCLES == 0) || (state == ST_WAIT && cnt == 4'd0);
  // hold the accepted request and count down the wait states
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (start) begin
      cnt       <= 4'(WAIT_CYCLES - 1);
      lat_we    <= req_we;
      lat_addr  <= req_addr[14:0];
      lat_wdata <= req_wdata;
    end else if (state == ST_WAIT) begin
      cnt <= cnt - 4'd1;
    end
`else
  assign we    = req_we;
  assign addr  = req_addr[14:0];
  assign wdata = req_wdata;
  assign fire  = start;
`endif

  assign ofs  = addr[2:0];
  assign miss = addr[14:3] != 12'd0 || ofs == 3'd7;
  assign wr   = fire && we && !miss;
  assign ack  = state == ST_RESP;
  assign irq  = flag & ctrl[CTRL_IEN];

  // next state: fire enters the ack cycle, otherwise an accepted request waits
  always_comb begin
    state_nx = state == ST_RESP ? ST_IDLE : fire ? ST_RESP : start ? ST_WAIT : state;
  end

  // state register and registered response
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      rdata <= (fire && !we && !miss) ? rd_val : '0;
      err   <= fire && miss;
    end

  // read mux over the register bank
  always_comb begin
    case (ofs)
      OFS_STATUS:   rd_val = {15'd0, flag};
      OFS_CTRL:     rd_val = {14'd0, ctrl};
      OFS_TIMER:    rd_val = count;
      OFS_CMP:      rd_val = cmp;
      OFS_GPIO_OUT: rd_val = 16'(gpio_out);
      OFS_GPIO_IN:  rd_val = 16'(gpio_sync);
      OFS_SCRATCH:  rd_val = scratch;
      default:      rd_val = '0;
    endcase
  end

  // writable registers, committed on the edge that enters the ack cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ctrl     <= '0;
      cmp      <= 16'hFFFF;
      gpio_out <= '0;
      scratch  <= '0;
    end else begin
      if (wr && ofs == OFS_CTRL) ctrl <= wdata[1:0];
      if (wr && ofs == OFS_CMP) cmp <= wdata;
      if (wr && ofs == OFS_GPIO_OUT) gpio_out <= wdata[GPIO_W-1:0];
      if (wr && ofs == OFS_SCRATCH) scratch <= wdata;
    end

  // two-flop synchroniser for the asynchronous gpio inputs
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      gpio_meta <= '0;
      gpio_sync <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
    end

  periph_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (ctrl[CTRL_TEN]),
    .load     (wr && ofs == OFS_TIMER),
    .load_val (wdata),
    .cmp      (cmp),
    .w1c      (wr && ofs == OFS_STATUS && wdata[0]),
    .count    (count),
    .flag     (flag)
  );
endmodule

// File: tb/tb_periph_responder.sv
// tb_periph_responder: directed self-checking bench for periph_responder in either wait-state build
module tb_periph_responder;
`ifdef PERIPH_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif
  localparam int INC = 2 + W;

  logic clk = 1'b0, reset_n = 1'b0, req = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0, rdata;
  logic ack, err, irq;
  logic [7:0] gpio_out, gpio_in = '0;
  int checks = 0, errs = 0, acks = 0, acks0, lat;
  logic [15:0] rd;
  logic e;

  periph_responder #(.GPIO_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err), .irq(irq),
    .gpio_out(gpio_out), .gpio_in(gpio_in)
  );

  always #5 clk = ~clk;
  always @(posedge ack) acks++;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d);
    logic got;
    @(negedge clk);
    req = 1'b1; req_we = w; req_addr = a; req_wdata = d;
    got = 1'b0; lat = 0; rd = 'x; e = 1'bx;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack) begin got = 1'b1; rd = rdata; e = err; end
    end
    req = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    chk("ack_width", 32'(ack), 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    access(1'b0, a, 16'h0);
    chk(tag, 32'(rd), 32'(exp));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outs", {29'd0, ack, err, irq}, 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_gpio_out", 32'(gpio_out), 32'd0);
    reset_n = 1'b1;

    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_addr = 16'h8006; req_wdata = 16'h1234;
    if (W > 0) begin @(posedge clk); #1; end
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req = 1'b0; reset_n = 1'b1;
    chk("midrst_no_ack", 32'(acks), 32'd0);
    rd_chk("midrst_scratch", 16'h8006, 16'h0000);
    rd_chk("midrst_cmp", 16'h8003, 16'hFFFF);
    chk("midrst_gpio_out", 32'(gpio_out), 32'd0);

    access(1'b1, 16'h8004, 16'h00A5);
    chk("gpio_wr_lat", 32'(lat), 32'(1 + W));
    chk("gpio_wr_err", 32'(e), 32'd0);
    chk("gpio_out", 32'(gpio_out), 32'h00A5);
    rd_chk("gpio_rd", 16'h8004, 16'h00A5);
    chk("gpio_rd_lat", 32'(lat), 32'(1 + W));

    @(negedge clk);
    acks0 = acks;
    req = 1'b1; req_we = 1'b1; req_addr = 16'h0004; req_wdata = 16'h00FF;
    repeat (10) @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("ram_no_ack", 32'(acks), 32'(acks0));
    rd_chk("ram_no_change", 16'h8004, 16'h00A5);
    chk("ram_gpio_out", 32'(gpio_out), 32'h00A5);
    rd_chk("unmap7_rdata", 16'h8007, 16'h0000);
    chk("unmap7_err", 32'(e), 32'd1);
    access(1'b1, 16'h8007, 16'hBEEF);
    chk("unmap7_wr_err", 32'(e), 32'd1);
    rd_chk("unmap_hi_rdata", 16'h8008, 16'h0000);
    chk("unmap_hi_err", 32'(e), 32'd1);
    access(1'b1, 16'h8006, 16'h5A5A);
    rd_chk("scratch", 16'h8006, 16'h5A5A);
    chk("scratch_err", 32'(e), 32'd0);

    access(1'b1, 16'h8003, 16'd5);
    access(1'b1, 16'h8002, 16'd0);
    access(1'b1, 16'h8001, 16'd3);
    repeat (4) @(posedge clk);
    #1 chk("irq_before_match", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_at_match", 32'(irq), 32'd1);
    rd_chk("status_set", 16'h8000, 16'h0001);
    rd_chk("ctrl_rd", 16'h8001, 16'h0003);
    access(1'b1, 16'h8000, 16'h0001);
    chk("irq_after_w1c", 32'(irq), 32'd0);
    rd_chk("status_clr", 16'h8000, 16'h0000);
    access(1'b1, 16'h8001, 16'd0);

    access(1'b1, 16'h8003, 16'h1234);
    access(1'b1, 16'h8002, 16'(17'h0FFFF - INC));
    access(1'b1, 16'h8001, 16'd1);
    access(1'b1, 16'h8001, 16'd0);
    rd_chk("timer_ffff", 16'h8002, 16'hFFFF);
    access(1'b1, 16'h8002, 16'(17'h10000 - INC));
    access(1'b1, 16'h8001, 16'd1);
    access(1'b1, 16'h8001, 16'd0);
    rd_chk("timer_wrap0", 16'h8002, 16'h0000);
    rd_chk("wrap_no_flag", 16'h8000, 16'h0000);

    access(1'b1, 16'h8002, 16'd0);
    access(1'b1, 16'h8001, 16'd1);
    access(1'b1, 16'h8002, 16'h0100);
    access(1'b1, 16'h8001, 16'd0);
    rd_chk("load_wins", 16'h8002, 16'(16'h0100 + INC));

    gpio_in = 8'h3C;
    rd_chk("gpio_in_early", 16'h8005, (W + 1 >= 3) ? 16'h003C : 16'h0000);
    rd_chk("gpio_in_sync", 16'h8005, 16'h003C);
    access(1'b1, 16'h8005, 16'h00FF);
    chk("gpio_in_wr_err", 32'(e), 32'd0);
    rd_chk("gpio_in_ro", 16'h8005, 16'h003C);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
